axi4lite_to_wb_bridge: RTL and testbench

AXI4-Lite slave to Wishbone classic master bridge, the inbound counterpart of the team's Wishbone-to-AXI4-Lite bridge. Lets AXI4-Lite initiators (CPU cluster, DMA) reach Wishbone peripherals. Buffers one AW, one W and one AR beat, arbitrates read against write, and runs one Wishbone classic cycle at a time. Maps ack/err/rty onto AXI responses.

---
 rtl/axi4lite_to_wb_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_axi4lite_to_wb_bridge.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_to_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge: one buffered AW, W and AR beat, one WB cycle at a time.
// Optional Wishbone stall abort (DECERR response) is enabled by defining AXI_WB_TIMEOUT_EN.
`timescale 1ns/1ps
module axi4lite_to_wb_bridge #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   s_axi_awaddr,
    input  logic [2:0]      s_axi_awprot,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [DW-1:0]   s_axi_wdata,
    input  logic [DW/8-1:0] s_axi_wstrb,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    output logic [1:0]      s_axi_bresp,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    input  logic [AW-1:0]   s_axi_araddr,
    input  logic [2:0]      s_axi_arprot,
    input  logic            s_axi_arvalid,
    output logic            s_axi_arready,
    output logic [DW-1:0]   s_axi_rdata,
    output logic [1:0]      s_axi_rresp,
    output logic            s_axi_rvalid,
    input  logic            s_axi_rready,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, BRESP, RRESP} state_t;
    state_t r_state, w_state_next;

    logic          r_aw_full, r_w_full, r_ar_full;
    logic          r_awready, r_wready, r_arready;
    logic [AW-1:0] r_awaddr, r_araddr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic          r_last_wr, w_last_wr_next;
    logic          r_cyc_stb, w_cyc_stb_next;
    logic          r_we, w_we_next;
    logic [AW-1:0] r_adr, w_adr_next;
    logic [DW-1:0] r_dat, w_dat_next;
    logic [SW-1:0] r_sel, w_sel_next;
    logic          r_bvalid, w_bvalid_next;
    logic [1:0]    r_bresp, w_bresp_next;
    logic          r_rvalid, w_rvalid_next;
    logic [1:0]    r_rresp, w_rresp_next;
    logic [DW-1:0] r_rdata, w_rdata_next;
    logic          w_clr_wr, w_clr_rd;
    logic          w_aw_hs, w_w_hs, w_ar_hs;
    logic          w_aw_full_next, w_w_full_next, w_ar_full_next;
    logic          w_term, w_fail, w_tmo;
    logic          w_unused_ok;

    assign w_aw_hs = s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi_wvalid & r_wready;
    assign w_ar_hs = s_axi_arvalid & r_arready;

    // A buffer can only be cleared in a response state, where its ready is low, so set and clear never collide.
    assign w_aw_full_next = w_clr_wr ? 1'b0 : (r_aw_full | w_aw_hs);
    assign w_w_full_next  = w_clr_wr ? 1'b0 : (r_w_full | w_w_hs);
    assign w_ar_full_next = w_clr_rd ? 1'b0 : (r_ar_full | w_ar_hs);

    assign w_term = r_cyc_stb & (wb_ack_i | wb_err_i | wb_rty_i);
    assign w_fail = wb_err_i | wb_rty_i;

`ifdef AXI_WB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i || !r_cyc_stb) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_tmo = r_cyc_stb & (r_tmo_cnt == 16'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot, 16'(TIMEOUT)};

    always_comb begin
        w_state_next   = r_state;
        w_last_wr_next = r_last_wr;
        w_cyc_stb_next = r_cyc_stb;
        w_we_next      = r_we;
        w_adr_next     = r_adr;
        w_dat_next     = r_dat;
        w_sel_next     = r_sel;
        w_bvalid_next  = r_bvalid;
        w_bresp_next   = r_bresp;
        w_rvalid_next  = r_rvalid;
        w_rresp_next   = r_rresp;
        w_rdata_next   = r_rdata;
        w_clr_wr       = 1'b0;
        w_clr_rd       = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the type that did not go last wins.
                if (r_ar_full && (!(r_aw_full && r_w_full) || r_last_wr)) begin
                    w_state_next   = WB_RD;
                    w_cyc_stb_next = 1'b1;
                    w_we_next      = 1'b0;
                    w_adr_next     = r_araddr;
                    w_sel_next     = '1;
                end else if (r_aw_full && r_w_full) begin
                    w_state_next   = WB_WR;
                    w_cyc_stb_next = 1'b1;
                    w_we_next      = 1'b1;
                    w_adr_next     = r_awaddr;
                    w_dat_next     = r_wdata;
                    w_sel_next     = r_wstrb;
                end
            end
            WB_WR: begin
                if (w_term || w_tmo) begin
                    w_state_next   = BRESP;
                    w_cyc_stb_next = 1'b0;
                    w_we_next      = 1'b0;
                    w_bvalid_next  = 1'b1;
                    w_bresp_next   = w_term ? (w_fail ? 2'b10 : 2'b00) : 2'b11;
                end
            end
            WB_RD: begin
                if (w_term || w_tmo) begin
                    w_state_next   = RRESP;
                    w_cyc_stb_next = 1'b0;
                    w_rvalid_next  = 1'b1;
                    w_rresp_next   = w_term ? (w_fail ? 2'b10 : 2'b00) : 2'b11;
                    w_rdata_next   = (w_term && !w_fail) ? wb_dat_i : '0;
                end
            end
            BRESP: begin
                if (s_axi_bready) begin
                    w_state_next   = IDLE;
                    w_bvalid_next  = 1'b0;
                    w_clr_wr       = 1'b1;
                    w_last_wr_next = 1'b1;
                end
            end
            RRESP: begin
                if (s_axi_rready) begin
                    w_state_next   = IDLE;
                    w_rvalid_next  = 1'b0;
                    w_clr_rd       = 1'b1;
                    w_last_wr_next = 1'b0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state   <= IDLE;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_ar_full <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_last_wr <= 1'b1;
            r_cyc_stb <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_aw_full <= w_aw_full_next;
            r_w_full  <= w_w_full_next;
            r_ar_full <= w_ar_full_next;
            r_awready <= ~w_aw_full_next;
            r_wready  <= ~w_w_full_next;
            r_arready <= ~w_ar_full_next;
            r_last_wr <= w_last_wr_next;
            r_cyc_stb <= w_cyc_stb_next;
            r_we      <= w_we_next;
            r_adr     <= w_adr_next;
            r_dat     <= w_dat_next;
            r_sel     <= w_sel_next;
            r_bvalid  <= w_bvalid_next;
            r_bresp   <= w_bresp_next;
            r_rvalid  <= w_rvalid_next;
            r_rresp   <= w_rresp_next;
            r_rdata   <= w_rdata_next;
        end
    end

    // Payload registers need no reset: they are only observed once the matching full flag is set.
    always_ff @(posedge wb_clk_i) begin
        if (w_aw_hs) r_awaddr <= s_axi_awaddr;
        if (w_ar_hs) r_araddr <= s_axi_araddr;
        if (w_w_hs) begin
            r_wdata <= s_axi_wdata;
            r_wstrb <= s_axi_wstrb;
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_arready = r_arready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign wb_adr_o      = r_adr;
    assign wb_dat_o      = r_dat;
    assign wb_sel_o      = r_sel;
    assign wb_we_o       = r_we;
    assign wb_cyc_o      = r_cyc_stb;
    assign wb_stb_o      = r_cyc_stb;
    assign wb_cti_o      = 3'b000;
    assign wb_bte_o      = 2'b00;
endmodule

// File: tb/tb_axi4lite_to_wb_bridge.sv
// Randomized self-checking bench for axi4lite_to_wb_bridge with a memory-backed Wishbone slave
// and a transaction-level reference model (memory image, arbitration history, expected responses).
`timescale 1ns/1ps
module tb_axi4lite_to_wb_bridge;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic awvalid, wvalid, arvalid, bready, rready;
    logic awready, wready, arready, bvalid, rvalid;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dato, wb_dati;
    logic [3:0] wb_sel;
    logic wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty;
    logic [2:0] wb_cti;
    logic [1:0] wb_bte;

    axi4lite_to_wb_bridge #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dato), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
        .wb_dat_i(wb_dati), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: kind 0 ack, 1 err, 2 rty, 3 silent; terminates after sl_delay full stb cycles.
    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];
    int sl_kind = 0;
    int sl_delay = 0;
    int scnt = 0;

    initial begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_dati = '0;
        forever begin
            @(posedge clk); #1;
            wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
            wb_dati = $urandom | 32'h1;
            if (wb_stb) begin
                scnt++;
                if (scnt > sl_delay && sl_kind != 3) begin
                    case (sl_kind)
                        0: begin
                            wb_ack = 1'b1;
                            if (wb_we) begin
                                for (int b = 0; b < 4; b++)
                                    if (wb_sel[b]) slv_mem[wb_adr[5:2]][8*b +: 8] = wb_dato[8*b +: 8];
                            end else begin
                                wb_dati = slv_mem[wb_adr[5:2]];
                            end
                        end
                        1: wb_err = 1'b1;
                        default: wb_rty = 1'b1;
                    endcase
                end
            end else begin
                scnt = 0;
            end
        end
    end

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          c;
    } wbreq_t;
    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    wbreq_t wq[$];
    rsp_t   bq[$];
    rsp_t   rq[$];
    int     stb_cnt = 0;

    initial begin
        wbreq_t r;
        rsp_t   p;
        logic   stb_prev;
        stb_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wb_stb && !stb_prev) begin
                r.adr = wb_adr; r.we = wb_we; r.sel = wb_sel; r.dat = wb_dato; r.c = cyc;
                wq.push_back(r);
            end
            if (wb_stb) stb_cnt++;
            stb_prev = wb_stb;
            if (bvalid && bready) begin p.resp = bresp; p.data = '0; bq.push_back(p); end
            if (rvalid && rready) begin p.resp = rresp; p.data = rdata; rq.push_back(p); end
        end
    end

    int  hs_aw, hs_w, hs_ar;
    logic m_last_wr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
        return m;
    endfunction

    task automatic aw_send(input logic [31:0] a, input int gap);
        bit ok = 0;
        repeat (gap) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; hs_aw = cyc;
        if (!ok) check_eq("aw_handshake_timeout", 0, 1);
        else check_eq("awready_low_after_hs", awready, 0);
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input int gap);
        bit ok = 0;
        repeat (gap) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        wvalid = 1'b0; hs_w = cyc;
        if (!ok) check_eq("w_handshake_timeout", 0, 1);
        else check_eq("wready_low_after_hs", wready, 0);
    endtask

    task automatic ar_send(input logic [31:0] a, input int gap);
        bit ok = 0;
        repeat (gap) begin @(posedge clk); #1; end
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0; hs_ar = cyc;
        if (!ok) check_eq("ar_handshake_timeout", 0, 1);
        else check_eq("arready_low_after_hs", arready, 0);
    endtask

    task automatic wait_valid(input bit is_b, output int c);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (is_b ? bvalid : rvalid) begin c = cyc; return; end
        end
        check_eq(is_b ? "bvalid_timeout" : "rvalid_timeout", 0, 1);
        c = -1;
    endtask

    function automatic logic [1:0] exp_resp(input int kind);
        return (kind == 0) ? 2'b00 : (kind == 3) ? 2'b11 : 2'b10;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awgap, input int wgap, input int kind, input int dly, input int hold);
        int nq, ns, c, hs;
        wbreq_t r;
        sl_kind = kind; sl_delay = dly;
        nq = wq.size(); ns = stb_cnt;
        fork
            aw_send(a, awgap);
            w_send(d, s, wgap);
        join
        hs = (hs_aw > hs_w) ? hs_aw : hs_w;
        wait_valid(1, c);
        if (c >= 0) begin
            check_eq("b_latency", c - hs, (kind == 3) ? TO + 1 : dly + 2);
            check_eq("bresp", bresp, exp_resp(kind));
            check_eq("wr_stb_len", stb_cnt - ns, (kind == 3) ? TO : dly + 1);
            check_eq("wr_wb_cycles", wq.size() - nq, 1);
            if (wq.size() > nq) begin
                r = wq[nq];
                check_eq("wr_adr", r.adr, a);
                check_eq("wr_we", r.we, 1);
                check_eq("wr_sel", r.sel, s);
                check_eq("wr_dat", r.dat, d);
                check_eq("wr_start", r.c, hs + 1);
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("bvalid_held", bvalid, 1);
                check_eq("bresp_held", bresp, exp_resp(kind));
            end
            @(posedge clk); #1; bready = 1'b1;
            @(posedge clk); #1; bready = 1'b0;
            check_eq("bvalid_drop", bvalid, 0);
            check_eq("aw_w_ready_after_b", {awready, wready}, 2'b11);
        end
        if (kind == 0) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
        m_last_wr = 1'b1;
        sl_kind = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int gap, input int kind, input int dly, input int hold);
        int nq, ns, c;
        wbreq_t r;
        logic [31:0] ed;
        sl_kind = kind; sl_delay = dly;
        nq = wq.size(); ns = stb_cnt;
        ed = (kind == 0) ? ref_mem[a[5:2]] : 32'h0;
        ar_send(a, gap);
        wait_valid(0, c);
        if (c >= 0) begin
            check_eq("r_latency", c - hs_ar, (kind == 3) ? TO + 1 : dly + 2);
            check_eq("rresp", rresp, exp_resp(kind));
            check_eq("rdata", rdata, ed);
            check_eq("rd_stb_len", stb_cnt - ns, (kind == 3) ? TO : dly + 1);
            if (wq.size() > nq) begin
                r = wq[nq];
                check_eq("rd_adr", r.adr, a);
                check_eq("rd_we_sel", {r.we, r.sel}, 5'b01111);
            end else begin
                check_eq("rd_wb_cycles", wq.size() - nq, 1);
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("rvalid_held", rvalid, 1);
                check_eq("rdata_held", rdata, ed);
                check_eq("arready_busy", arready, 0);
            end
            @(posedge clk); #1; rready = 1'b1;
            @(posedge clk); #1; rready = 1'b0;
            check_eq("rvalid_drop", rvalid, 0);
            check_eq("arready_after_r", arready, 1);
        end
        m_last_wr = 1'b0;
        sl_kind = 0;
    endtask

    // Write and read pending together; the model expects the type opposite the last one served.
    task automatic do_pair(input int wi, input int ri, input logic [31:0] d, input logic [3:0] s);
        int nq, nb, nr;
        bit done = 0;
        logic exp_we;
        sl_kind = 0; sl_delay = $urandom_range(0, 3);
        nq = wq.size(); nb = bq.size(); nr = rq.size();
        exp_we = ~m_last_wr;
        bready = 1'b1; rready = 1'b1;
        fork
            aw_send({26'h0, wi[3:0], 2'b00}, 0);
            w_send(d, s, 0);
            ar_send({26'h0, ri[3:0], 2'b00}, 0);
        join
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bq.size() > nb && rq.size() > nr) begin done = 1; break; end
        end
        if (!done) check_eq("pair_timeout", 0, 1);
        else begin
            check_eq("arb_first_we", wq[nq].we, exp_we);
            check_eq("pair_bresp", bq[nb].resp, 2'b00);
            check_eq("pair_rresp", rq[nr].resp, 2'b00);
            check_eq("pair_rdata", rq[nr].data, ref_mem[ri]);
        end
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        ref_mem[wi] = merge(ref_mem[wi], d, s);
        m_last_wr = ~exp_we;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int op, k, wi, ri, nb;
        bit seen;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        slv_mem[1] = 32'h12345678;
        ref_mem[1] = 32'h12345678;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        rst_n = 1'b0;
        m_last_wr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_readies", {awready, wready, arready}, 3'b000);
        check_eq("rst_valids", {bvalid, rvalid}, 2'b00);
        check_eq("rst_wb", {wb_cyc, wb_stb, wb_we}, 3'b000);
        check_eq("rst_resp", {bresp, rresp}, 4'b0000);
        check_eq("rst_rdata", rdata, 0);
        check_eq("wb_cti_bte", {wb_cti, wb_bte}, 5'b00000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("readies_after_rst", {awready, wready, arready}, 3'b111);

        // Tie right after reset: read first; after a lone read, the next tie goes to the write.
        do_pair(2, 3, $urandom, 4'hF);
        do_read(32'h0000_0014, 0, 0, 1, 0);
        do_pair(6, 7, $urandom, 4'h5);

        do_write(32'h0000_0100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 3, 0);
        do_read(32'h0000_0104, 0, 0, 2, 4);
        do_write(32'h0000_0008, $urandom, 4'hF, 5, 0, 0, 1, 1);
        do_read(32'h0000_0018, 0, 1, 1, 1);
        do_write(32'h0000_001C, $urandom, 4'hF, 0, 0, 2, 2, 1);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 6);
            k = $urandom_range(0, 9);
            k = (k < 7) ? 0 : (k < 9) ? 1 : 2;
            if (op < 3) begin
                do_write($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), k, $urandom_range(0, 4), $urandom_range(0, 3));
            end else if (op < 6) begin
                do_read($urandom & 32'hFFFF_FFFC, $urandom_range(0, 2), k, $urandom_range(0, 4), $urandom_range(0, 3));
            end else begin
                wi = $urandom_range(0, 15);
                ri = (wi + $urandom_range(1, 15)) % 16;
                do_pair(wi, ri, $urandom, 4'($urandom_range(0, 15)));
            end
        end

`ifdef AXI_WB_TIMEOUT_EN
        do_write(32'h0000_0020, $urandom, 4'hF, 0, 0, 3, 0, 1);
        do_read(32'h0000_0024, 0, 3, 0, 1);
`endif

        // Reset during an outstanding write with a silent slave.
        sl_kind = 3;
        fork
            aw_send(32'h0000_003C, 0);
            w_send(32'hCAFEF00D, 4'hF, 0);
        join
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_stb) begin seen = 1; break; end
        end
        check_eq("abort_stb_seen", seen, 1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
        check_eq("abort_valids", {bvalid, rvalid}, 2'b00);
        rst_n = 1'b1; sl_kind = 0; bready = 1'b1;
        nb = bq.size();
        repeat (10) @(negedge clk);
        check_eq("abort_no_bresp", bq.size() - nb, 0);
        check_eq("abort_no_stb", wb_stb, 0);
        @(posedge clk); #1; bready = 1'b0;
        m_last_wr = 1'b1;

        do_write(32'h0000_0030, 32'hA5A5_5A5A, 4'hF, 0, 1, 0, 0, 0);
        do_read(32'h0000_0030, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
